// File: rtl/mem_responder.sv
// Single-outstanding memory responder: valid/ready request in, fixed LATENCY wait states, valid/ready response out.
// Optional feature macro MEM_RESP_OOB_ERR_EN: addresses >= depth get resp_err=1 instead of aliasing modulo depth.
module mem_responder #(
    parameter int depth   = 2048,
    parameter int width   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [width-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [width-1:0] resp_rdata,
    output logic             resp_err,
    output logic             busy
);
    localparam int AW = $clog2(depth);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             write_q;
    logic             oob_q;
    logic [AW-1:0]    idx_q;
    logic [width-1:0] wdata_q;
    logic [width-1:0] rdata_q;
    logic             valid_q;
    logic             err_q;
    logic [width-1:0] mem_q [depth];

    logic accept;
    logic commit;
    logic mem_we;
    logic req_oob;

    assign req_ready  = (state_q == IDLE) & ~rst;
    assign accept     = req_valid & req_ready;
    assign commit     = (state_q == WAIT) && (cnt_q == '0);
    assign mem_we     = commit & write_q & ~oob_q;

    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != IDLE);

`ifdef MEM_RESP_OOB_ERR_EN
    assign req_oob = (req_addr >= 32'(depth));
`else
    logic unused_addr_hi;
    assign req_oob        = 1'b0;
    assign unused_addr_hi = ^req_addr[31:AW];
`endif

    // LATENCY==1 enters WAIT with the counter already at 0, so the commit
    // edge is always exactly LATENCY edges after the accept edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            oob_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q <= req_write;
                        oob_q   <= req_oob;
                        idx_q   <= req_addr[AW-1:0];
                        wdata_q <= req_wdata;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q <= (write_q | oob_q) ? '0 : mem_q[idx_q];
                        err_q   <= oob_q;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the array is deliberately not reset; a reset loop over every word
    // would prevent RAM inference. Reset still blocks writes via state_q.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end
endmodule
